// File: rtl/usbfs_bit_tx_if.sv
// usbfs_bit_tx_if: serial bit handshake between the packet sender and the bit transmitter
interface usbfs_bit_tx_if;
  logic tx_sta;
  logic tx_req;
  logic tx_bit;
  logic tx_fin;
  modport master(output tx_sta, output tx_bit, output tx_fin, input tx_req);
  modport slave(input tx_sta, input tx_bit, input tx_fin, output tx_req);
endinterface

// File: rtl/usbfs_bit_tx.sv
// usbfs_bit_tx: USB FS bit transmitter adding SYNC, bit stuffing, NRZI encoding and EOP
module usbfs_bit_tx #(
  parameter int CLK_DIV = 5
) (
  input  logic          clk,
  input  logic          rstn,
  usbfs_bit_tx_if.slave tx,
  output logic          usb_oe,
  output logic          usb_dp_tx,
  output logic          usb_dn_tx,
  output logic          tx_busy
);
  localparam int PW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
  state_t state;
  logic [PW-1:0] phase;
  logic [2:0] idx, ones, nxt_ones;
  logic lvl, bit_q, fin_q, wrap, stuff, req_slot, sync_j, nxt_lvl;
  // next-slot decisions; ones only moves at slot starts, so it is stable for the whole slot
  always_comb begin
    wrap = phase == PW'(CLK_DIV - 1);
    stuff = state == DATA && ones == 3'd6;
    req_slot = (state == SYNC && idx == 3'd7) || (state == DATA && !stuff);
    sync_j = !idx[0] && idx != 3'd6;
    nxt_lvl = stuff || !bit_q ? !lvl : lvl;
    nxt_ones = stuff || !bit_q ? 3'd0 : ones + 3'd1;
  end
  // slot sequencer: line outputs only change at the wrap into phase 0; lvl=1 means J
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      phase <= '0;
      idx <= '0;
      ones <= '0;
      lvl <= 1'b0;
      bit_q <= 1'b0;
      fin_q <= 1'b0;
      tx.tx_req <= 1'b0;
      usb_oe <= 1'b0;
      usb_dp_tx <= 1'b1;
      usb_dn_tx <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      phase <= state == IDLE || wrap ? '0 : phase + 1'b1;
      tx.tx_req <= phase == '0 && req_slot;
      if (phase == PW'(2)) begin
        bit_q <= tx.tx_bit;
        fin_q <= tx.tx_fin;
      end
      case (state)
        IDLE: if (tx.tx_sta) begin
          state <= SYNC;
          idx <= '0;
          ones <= '0;
          lvl <= 1'b0;
          usb_oe <= 1'b1;
          tx_busy <= 1'b1;
          usb_dp_tx <= 1'b0;
          usb_dn_tx <= 1'b1;
        end
        SYNC, DATA: if (wrap) begin
          if (state == SYNC && idx != 3'd7) begin
            idx <= idx + 3'd1;
            ones <= 3'd1;
            lvl <= 1'b0;
            usb_dp_tx <= sync_j;
            usb_dn_tx <= !sync_j;
          end else if (!stuff && fin_q) begin
            state <= EOP_SE0;
            idx <= '0;
            usb_dp_tx <= 1'b0;
            usb_dn_tx <= 1'b0;
          end else begin
            state <= DATA;
            lvl <= nxt_lvl;
            ones <= nxt_ones;
            usb_dp_tx <= nxt_lvl;
            usb_dn_tx <= !nxt_lvl;
          end
        end
        EOP_SE0: if (wrap) begin
          idx <= idx + 3'd1;
          if (idx[0]) begin
            state <= EOP_J;
            usb_dp_tx <= 1'b1;
          end
        end
        EOP_J: if (wrap) begin
          state <= IDLE;
          usb_oe <= 1'b0;
          tx_busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          usb_oe <= 1'b0;
          tx_busy <= 1'b0;
          usb_dp_tx <= 1'b1;
          usb_dn_tx <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_usbfs_bit_tx.sv
// tb_usbfs_bit_tx: vector table, directed corners and random packets against a slot-level line model
module tb_usbfs_bit_tx;
  localparam int D = 5;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
  localparam logic [4:0] IDLE_OUT = 5'b01000;
  typedef struct { logic [1:0] line; bit req; } slot_t;
  typedef struct { logic [31:0] bits; int n; int slots; int reqs; } vec_t;
  logic clk = 1'b0, rstn = 1'b1;
  logic usb_oe, usb_dp_tx, usb_dn_tx, tx_busy;
  int vectors = 0, errors = 0;
  logic [1:0] obs[$];
  slot_t sl[$];
  logic [1:0] ack_line[19] = '{K, J, K, J, K, J, K, K, J, J, K, J, J, K, K, K, SE0, SE0, J};

  usbfs_bit_tx_if bus();
  usbfs_bit_tx #(.CLK_DIV(D)) dut (
    .clk(clk), .rstn(rstn), .tx(bus),
    .usb_oe(usb_oe), .usb_dp_tx(usb_dp_tx), .usb_dn_tx(usb_dn_tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s oe/dp/dn/req/busy got %b want %b", name, act, want);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  // line slots of a packet: SYNC, NRZI data with a stuffed 0 after every six 1s, EOP;
  // req marks slots whose content the transmitter must ask the sender for
  function automatic void build(input bit b[$]);
    logic [1:0] lv;
    int ones;
    lv = K;
    ones = 1;
    sl.delete();
    for (int i = 0; i < 8; i++) sl.push_back('{(i % 2 == 0 || i == 7) ? K : J, 1'b0});
    foreach (b[i]) begin
      if (b[i]) ones++;
      else begin
        lv = ~lv;
        ones = 0;
      end
      sl.push_back('{lv, 1'b1});
      if (ones == 6) begin
        lv = ~lv;
        ones = 0;
        sl.push_back('{lv, 1'b0});
      end
    end
    sl.push_back('{SE0, 1'b1});
    sl.push_back('{SE0, 1'b0});
    sl.push_back('{J, 1'b0});
  endfunction

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 bus.tx_sta = 1'b0;
      bus.tx_fin = 1'($urandom);
      bus.tx_bit = 1'($urandom);
      @(negedge clk);
      check(name, {usb_oe, usb_dp_tx, usb_dn_tx, bus.tx_req, tx_busy}, IDLE_OUT);
    end
  endtask

  task automatic run(input string name, input bit b[$], input bit noise, input int abort_at,
                     input int exp_oe, input int exp_req);
    bit q[$];
    bit prev;
    int oe_n, req_n, ns;
    q = b;
    prev = 1'b0;
    oe_n = 0;
    req_n = 0;
    build(b);
    ns = sl.size();
    obs.delete();
    for (int c = 0; c <= ns * D; c++) begin
      int k, ph;
      logic [4:0] want;
      @(posedge clk);
      if (c == abort_at) begin
        #2 rstn = 1'b0;
        #1 check({name, "/async_rst"}, {usb_oe, usb_dp_tx, usb_dn_tx, bus.tx_req, tx_busy}, IDLE_OUT);
        bus.tx_sta = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      #1 bus.tx_sta = c == 0 || (noise && $urandom_range(0, 3) == 0);
      bus.tx_fin = prev ? q.size() == 0 : $urandom_range(0, 7) == 0;
      bus.tx_bit = prev && q.size() != 0 ? q.pop_front() : 1'($urandom);
      @(negedge clk);
      k = c == 0 ? ns : (c - 1) / D;
      ph = c == 0 ? 0 : (c - 1) % D;
      want = k < ns ? {1'b1, sl[k].line, ph == 1 && k + 1 < ns && sl[k + 1].req, 1'b1} : IDLE_OUT;
      check($sformatf("%s/c%0d", name, c), {usb_oe, usb_dp_tx, usb_dn_tx, bus.tx_req, tx_busy}, want);
      if (k < ns && ph == 0) obs.push_back({usb_dp_tx, usb_dn_tx});
      oe_n += int'(usb_oe);
      req_n += int'(bus.tx_req);
      prev = bus.tx_req;
    end
    check_int({name, "/bits_left"}, q.size(), 0);
    if (exp_oe >= 0) begin
      check_int({name, "/oe_cycles"}, oe_n, exp_oe);
      check_int({name, "/req_pulses"}, req_n, exp_req);
    end
  endtask

  initial begin
    vec_t tab[7];
    bit b[$];
    bit ack[$];
    tab[0] = '{32'h0000_00D2, 8, 19, 9};
    tab[1] = '{32'h0000_FFC3, 16, 28, 17};
    tab[2] = '{32'h0000_007E, 7, 19, 8};
    tab[3] = '{32'h0000_0000, 0, 11, 1};
    tab[4] = '{32'h0000_0000, 8, 19, 9};
    tab[5] = '{32'h0000_001F, 6, 18, 7};
    tab[6] = '{32'h0000_0FFF, 12, 25, 13};
    bus.tx_sta = 1'b0;
    bus.tx_bit = 1'b0;
    bus.tx_fin = 1'b0;
    #1 rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 bus.tx_sta = 1'($urandom);
      bus.tx_fin = 1'($urandom);
      bus.tx_bit = 1'($urandom);
      @(negedge clk);
      check("in_reset", {usb_oe, usb_dp_tx, usb_dn_tx, bus.tx_req, tx_busy}, IDLE_OUT);
    end
    rstn = 1'b1;
    idle("post_reset", 4);
    for (int i = 0; i < 7; i++) begin
      b.delete();
      for (int j = 0; j < tab[i].n; j++) b.push_back(tab[i].bits[j]);
      run($sformatf("vec%0d", i), b, 1'b0, -1, tab[i].slots * D, tab[i].reqs);
      if (i == 0) begin
        ack = b;
        foreach (ack_line[s]) check_int($sformatf("ack_slot%0d", s), int'(obs[s]), int'(ack_line[s]));
      end
      idle("gap", 2);
    end
    run("sta_noise", ack, 1'b1, -1, 95, 9);
    run("back2back", ack, 1'b0, -1, 95, 9);
    b.delete();
    for (int j = 0; j < 24; j++) b.push_back(1'($urandom));
    run("abort", b, 1'b0, 13 * D + 3, -1, -1);
    idle("after_abort", 3);
    run("post_abort", ack, 1'b0, -1, 95, 9);
    for (int r = 0; r < 20; r++) begin
      b.delete();
      for (int j = 0; j < int'($urandom_range(0, 40)); j++) b.push_back($urandom_range(0, 3) != 0);
      run($sformatf("rnd%0d", r), b, 1'($urandom), -1, -1, -1);
      idle("rnd_gap", int'($urandom_range(0, 3)));
    end
    idle("end", 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/usbfs_bit_tx.md
Name: usbfs_bit_tx

Overview:
Bit-level USB Full Speed transmitter. It sits directly downstream of the device packet sender and consumes its serial bit stream (tx_sta / tx_req / tx_bit / tx_fin). It adds the SYNC pattern, applies bit stuffing and NRZI encoding, appends EOP, and drives the D+/D- line with an output enable. One bit slot lasts CLK_DIV clock cycles; with a 60 MHz clock and CLK_DIV=5 the line rate is 12 Mbps.

Parameters:
CLK_DIV, 5, clock cycles per USB bit slot; legal range 4..16.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
tx_sta  input  1  one-cycle packet start pulse; honoured only in IDLE
tx_req  output  1  one-cycle request for the next packet bit
tx_bit  input  1  packet bit, valid the cycle after tx_req
tx_fin  input  1  end-of-packet flag, valid the cycle after tx_req; overrides tx_bit
usb_oe  output  1  line output enable
usb_dp_tx  output  1  D+ drive value
usb_dn_tx  output  1  D- drive value
tx_busy  output  1  high from the cycle after tx_sta until the last EOP J slot ends

Behaviour:
- Reset is asynchronous, active-low, and immediate, including mid-packet. Reset values: tx_req=0, usb_oe=0, usb_dp_tx=1, usb_dn_tx=0 (J), tx_busy=0, state=IDLE, phase=0, ones=0.
- Line encoding: J = (dp=1, dn=0), K = (dp=0, dn=1), SE0 = (0, 0).
- All outputs are registered. usb_dp_tx, usb_dn_tx and usb_oe change only at phase 0 of a slot. A phase counter runs 0..CLK_DIV-1 and wraps.
- IDLE: usb_oe=0, line held at J, phase held at 0. On tx_sta, on the next cycle: usb_oe=1, tx_busy=1, first SYNC slot begins at phase 0, state goes to SYNC. tx_sta is ignored in any other state.
- SYNC: 8 slots driving K J K J K J K K. After SYNC the NRZI level is K and ones=1, because the final SYNC bit counts toward stuffing.
- Look-ahead: the content of slot N+1 is decided during slot N.
  - Request path: tx_req=1 at phase 1; tx_bit/tx_fin sampled at phase 2.
  - In SYNC slot 7 the first packet bit is requested.
  - In each DATA slot:
    - If ones==6, the next slot is a stuffed 0, no tx_req is issued, and ones=0.
    - Otherwise tx_req is issued and the sampled response is applied:
      - tx_fin=1: next slot starts EOP.
      - bit 1: hold the NRZI level, ones+1.
      - bit 0: toggle the NRZI level, ones=0.
- Stuffing also applies after the final data bit. If the last bit makes ones==6, a stuffed slot is inserted before tx_fin is requested, so EOP follows the stuff bit.
- EOP: SE0 for 2 slots, then J for 1 slot. Then usb_oe=0, tx_busy=0, state=IDLE; tx_sta is accepted again from the next cycle.
- tx_req is never asserted in IDLE, SYNC slots 0..6, stuffed-bit decision slots, or EOP. Minimum spacing between tx_req pulses is CLK_DIV cycles (at least 4).
- The upstream sender must answer every tx_req the next cycle with a bit or tx_fin. No timeout exists; tx_fin is the only terminator.
- State machine: IDLE -> SYNC -> DATA -> EOP_SE0 (2 slots) -> EOP_J -> IDLE. Any other encoding returns to IDLE.

Test Plan:
- Reset values: assert rstn=0 with random stimulus -> usb_oe=0, dp/dn=1/0, tx_req=0, tx_busy=0. Release rstn -> outputs stay idle until tx_sta.
- ACK packet (PID bits LSB-first 0,1,0,0,1,0,1,1, then tx_fin), CLK_DIV=5:
  - Line slots: K J K J K J K K, then J J K J J K K K, then SE0 SE0 J, then oe=0.
  - Exactly 9 tx_req pulses, 5 cycles apart.
  - usb_oe high for exactly 95 cycles.
- Stuffing with data 0xFF after PID DATA0 (bits 1,1,0,0,0,0,1,1 then eight 1s):
  - A forced transition is inserted after the 6th consecutive 1.
  - No tx_req occurs in that decision slot.
  - Total slots = 8+8+8+1+3 = 28.
- Trailing stuff: packet ends with six 1s (counting across bytes) -> stuffed 0 slot appears before SE0, and tx_fin is requested one slot later.
- Ignored start: tx_sta pulsed during SYNC and during EOP -> no restart, no extra tx_req. tx_sta one cycle after usb_oe falls -> new SYNC begins on the next cycle.
- Reset mid-packet: rstn=0 during DATA slot 5 -> usb_oe=0 in the same cycle. After release, a new tx_sta yields a clean SYNC with ones counter cleared.
